// File: rtl/trans_ctrl_fsm_if.sv
// Bundles the configuration, FIFO status and supervision outputs of
// trans_ctrl_fsm. The master side drives the requests and FIFO flags.
// The slave side is the controller itself.
interface trans_ctrl_fsm_if #(
  parameter int NFIFO     = 5,
  parameter int UMB_W     = 2,
  parameter int ERR_CNT_W = 8
);
  logic                 init;
  logic [UMB_W-1:0]     umbral_mf;
  logic [UMB_W-1:0]     umbral_vc;
  logic [UMB_W-1:0]     umbral_d;
  logic [NFIFO-1:0]     fifo_empties;
  logic [NFIFO-1:0]     fifo_errors;
  logic                 err_clear;

  logic [2:0]           state;
  logic                 init_out;
  logic                 idle_out;
  logic                 active_out;
  logic                 error_out;
  logic [UMB_W-1:0]     umbral_mf_out;
  logic [UMB_W-1:0]     umbral_vc_out;
  logic [UMB_W-1:0]     umbral_d_out;
  logic [NFIFO-1:0]     err_vector;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output init, umbral_mf, umbral_vc, umbral_d, fifo_empties, fifo_errors, err_clear,
    input  state, init_out, idle_out, active_out, error_out,
           umbral_mf_out, umbral_vc_out, umbral_d_out, err_vector, err_count
  );

  modport slave (
    input  init, umbral_mf, umbral_vc, umbral_d, fifo_empties, fifo_errors, err_clear,
    output state, init_out, idle_out, active_out, error_out,
           umbral_mf_out, umbral_vc_out, umbral_d_out, err_vector, err_count
  );
endinterface

// File: rtl/trans_ctrl_fsm.sv
// Transaction-layer control FSM: supervises NFIFO data FIFOs and gates
// traffic through RESET/INIT/IDLE/ACTIVE/ERROR. All outputs are registered.
// It provides threshold load/reload, an active-to-idle timeout, sticky
// per-FIFO error capture and a saturating count of ERROR entries.
module trans_ctrl_fsm #(
  parameter int NFIFO        = 5,
  parameter int UMB_W        = 2,
  parameter int IDLE_TIMEOUT = 8,
  parameter int ERR_CNT_W    = 8
) (
  input logic            clk,
  input logic            reset,
  trans_ctrl_fsm_if.slave bus
);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam int CNT_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  logic [2:0]           r_state;
  logic                 r_init_out;
  logic                 r_idle_out;
  logic                 r_active_out;
  logic                 r_error_out;
  logic [UMB_W-1:0]     r_umbral_mf;
  logic [UMB_W-1:0]     r_umbral_vc;
  logic [UMB_W-1:0]     r_umbral_d;
  logic [NFIFO-1:0]     r_err_vector;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0]     r_idle_cnt;

  logic [2:0]           w_next;
  logic                 w_load;
  logic                 w_all_empty;
  logic                 w_any_err;
  logic                 w_thr_nz;
  logic                 w_timeout;

  assign w_all_empty = &bus.fifo_empties;
  assign w_any_err   = |bus.fifo_errors;
  assign w_thr_nz    = |{bus.umbral_mf, bus.umbral_vc, bus.umbral_d};
  assign w_timeout   = w_all_empty && (r_idle_cnt == CNT_LAST);

  // Next-state decode and threshold-load request.
  always_comb begin
    w_next = ST_RESET;
    w_load = 1'b0;
    case (r_state)
      ST_RESET: w_next = ST_INIT;
      ST_INIT: begin
        if (bus.init && w_thr_nz) begin
          w_load = 1'b1;
          w_next = ST_IDLE;
        end else begin
          w_next = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (w_any_err) begin
          w_next = ST_ERROR;
        end else if (bus.init && w_thr_nz) begin
          w_load = 1'b1;
          w_next = ST_IDLE;
        end else if (w_all_empty) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (w_any_err)      w_next = ST_ERROR;
        else if (w_timeout) w_next = ST_IDLE;
        else                w_next = ST_ACTIVE;
      end
      ST_ERROR: begin
        if (bus.err_clear && !w_any_err) w_next = ST_RESET;
        else                             w_next = ST_ERROR;
      end
      default: w_next = ST_RESET;
    endcase
  end

  // State, flags, thresholds, error capture and idle counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_RESET;
      r_init_out   <= 1'b0;
      r_idle_out   <= 1'b0;
      r_active_out <= 1'b0;
      r_error_out  <= 1'b0;
      r_umbral_mf  <= '0;
      r_umbral_vc  <= '0;
      r_umbral_d   <= '0;
      r_err_vector <= '0;
      r_err_count  <= '0;
      r_idle_cnt   <= '0;
    end else begin
      r_state      <= w_next;
      r_init_out   <= w_load;
      // Flags follow the next state so they line up with the state output.
      r_idle_out   <= (w_next == ST_IDLE);
      r_active_out <= (w_next == ST_ACTIVE);
      r_error_out  <= (w_next == ST_ERROR);

      if (r_state == ST_ACTIVE && w_next == ST_ACTIVE && w_all_empty)
        r_idle_cnt <= r_idle_cnt + CNT_W'(1);
      else
        r_idle_cnt <= '0;

      if (w_next == ST_RESET) begin
        r_umbral_mf <= '0;
        r_umbral_vc <= '0;
        r_umbral_d  <= '0;
      end else if (w_load) begin
        r_umbral_mf <= bus.umbral_mf;
        r_umbral_vc <= bus.umbral_vc;
        r_umbral_d  <= bus.umbral_d;
      end

      if (w_next == ST_RESET)
        r_err_vector <= '0;
      else if (r_state == ST_IDLE || r_state == ST_ACTIVE || r_state == ST_ERROR)
        r_err_vector <= r_err_vector | bus.fifo_errors;

      if (w_next == ST_ERROR && r_state != ST_ERROR && r_err_count != '1)
        r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

  assign bus.state         = r_state;
  assign bus.init_out      = r_init_out;
  assign bus.idle_out      = r_idle_out;
  assign bus.active_out    = r_active_out;
  assign bus.error_out     = r_error_out;
  assign bus.umbral_mf_out = r_umbral_mf;
  assign bus.umbral_vc_out = r_umbral_vc;
  assign bus.umbral_d_out  = r_umbral_d;
  assign bus.err_vector    = r_err_vector;
  assign bus.err_count     = r_err_count;

endmodule
